// File: rtl/gpr_ctx_ctrl_if.sv
// -----------------------------------------------------------------------------
// gpr_ctx_ctrl_if
// Bundles the GPR access ports and the two context streams used by the
// context save/restore engine.
//   GPR read port  : gpr_rd_addr (engine->GPR), gpr_rd_data (GPR->engine, comb)
//   GPR write port : gpr_we_ (active-low), gpr_wr_addr, gpr_wr_data
//   Save stream    : tx_valid / tx_data (engine->sink), tx_ready (sink->engine)
//   Restore stream : rx_valid / rx_data (source->engine), rx_ready (engine->src)
// Modports: master = context engine side, slave = GPR / stream partner side.
// -----------------------------------------------------------------------------
interface gpr_ctx_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] gpr_rd_addr;
   logic [DATA_W-1:0] gpr_rd_data;
   logic              gpr_we_;
   logic [ADDR_W-1:0] gpr_wr_addr;
   logic [DATA_W-1:0] gpr_wr_data;
   logic              tx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_ready;
   logic              rx_valid;
   logic [DATA_W-1:0] rx_data;
   logic              rx_ready;

   modport master (
      output gpr_rd_addr,
      input  gpr_rd_data,
      output gpr_we_,
      output gpr_wr_addr,
      output gpr_wr_data,
      output tx_valid,
      output tx_data,
      input  tx_ready,
      input  rx_valid,
      input  rx_data,
      output rx_ready
   );

   modport slave (
      input  gpr_rd_addr,
      output gpr_rd_data,
      input  gpr_we_,
      input  gpr_wr_addr,
      input  gpr_wr_data,
      input  tx_valid,
      input  tx_data,
      output tx_ready,
      output rx_valid,
      output rx_data,
      input  rx_ready
   );
endinterface

// File: rtl/gpr_ctx_ctrl.sv
// -----------------------------------------------------------------------------
// gpr_ctx_ctrl
// Context save/restore engine for the general purpose register file.
// Save   : reads all REG_NUM registers through the GPR read port and streams
//          them out on tx_valid/tx_data, one word per cycle when tx_ready.
// Restore: accepts REG_NUM words on rx_valid/rx_data and writes each one back
//          through the GPR write port in the cycle after acceptance.
// pipe_stall (= busy) is held while the engine owns the register file.
//
// Ports:
//   clk_i            clock, rising edge
//   reset_i          synchronous active-high reset
//   start_save_i     one-cycle save request (IDLE only, wins over restore)
//   start_restore_i  one-cycle restore request (IDLE only)
//   busy_o           high in every state except IDLE
//   pipe_stall_o     copy of busy_o
//   done_o           one-cycle pulse at the end of an operation
//   csum_err_o       checksum mismatch of the last restore
//   bus              gpr_ctx_ctrl_if.master (GPR ports and both streams)
//
// Optional feature macro: GPR_CTX_CSUM_EN
//   Defined   : an XOR checksum word is appended to every save and checked
//               (not written) on every restore; csum_err_o reports mismatch.
//   Undefined : exactly REG_NUM words per transfer, csum_err_o stays 0.
// -----------------------------------------------------------------------------
module gpr_ctx_ctrl #(
   parameter int REG_NUM = 32,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic           start_save_i,
   input  logic           start_restore_i,
   output logic           busy_o,
   output logic           pipe_stall_o,
   output logic           done_o,
   output logic           csum_err_o,
   gpr_ctx_ctrl_if.master bus
);

   // One extra counter bit so idx can reach REG_NUM (the checksum slot).
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CSUM_IDX = CNT_W'(REG_NUM);
`ifdef GPR_CTX_CSUM_EN
   localparam logic [CNT_W-1:0] NWORDS   = CNT_W'(REG_NUM + 1);
`else
   localparam logic [CNT_W-1:0] NWORDS   = CNT_W'(REG_NUM);
`endif
   localparam logic [CNT_W-1:0] LAST_IDX = NWORDS - CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SAVE    = 2'd1,
      ST_RESTORE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Running XOR checksum over the transferred register words.
   function automatic logic [DATA_W-1:0] csum_fold(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] word);
      return acc ^ word;
   endfunction

   state_t            state_q,    state_d;
   logic [CNT_W-1:0]  idx_q,      idx_d;
   logic              tx_valid_q, tx_valid_d;
   logic [DATA_W-1:0] tx_data_q,  tx_data_d;
   logic              we_n_q,     we_n_d;
   logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
   logic [DATA_W-1:0] wr_data_q,  wr_data_d;
   logic [DATA_W-1:0] csum_q,     csum_d;
   logic              csum_err_q, csum_err_d;
   logic              busy_q,     busy_d;
   logic              done_q,     done_d;
   logic              rx_ready_q, rx_ready_d;
   logic              rx_take_s;

   // A restore word is accepted only while the registered ready is high.
   assign rx_take_s = bus.rx_valid && rx_ready_q;

   // Next-state and datapath decisions for the save/restore sequencer.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      we_n_d     = 1'b1;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      csum_d     = csum_q;
      csum_err_d = csum_err_q;

      case (state_q)
         ST_IDLE: begin
            if (start_save_i) begin
               state_d    = ST_SAVE;
               idx_d      = {CNT_W{1'b0}};
               csum_d     = {DATA_W{1'b0}};
               csum_err_d = 1'b0;
            end else if (start_restore_i) begin
               state_d    = ST_RESTORE;
               idx_d      = {CNT_W{1'b0}};
               csum_d     = {DATA_W{1'b0}};
               csum_err_d = 1'b0;
            end else begin
               state_d    = ST_IDLE;
            end
         end

         ST_SAVE: begin
            // Output slot free (empty or being consumed) and words remain:
            // load the next word; the checksum slot takes the folded value.
            if ((!tx_valid_q || bus.tx_ready) && (idx_q < NWORDS)) begin
               tx_valid_d = 1'b1;
               tx_data_d  = (idx_q == CSUM_IDX) ? csum_q : bus.gpr_rd_data;
               csum_d     = csum_fold(csum_q, bus.gpr_rd_data);
               idx_d      = idx_q + CNT_W'(1);
            end else if (tx_valid_q && bus.tx_ready) begin
               // Final word consumed.
               tx_valid_d = 1'b0;
               state_d    = ST_DONE;
            end else begin
               tx_valid_d = tx_valid_q;
            end
         end

         ST_RESTORE: begin
            if (rx_take_s) begin
               if (idx_q < CSUM_IDX) begin
                  we_n_d    = 1'b0;
                  wr_addr_d = idx_q[ADDR_W-1:0];
                  wr_data_d = bus.rx_data;
                  csum_d    = csum_fold(csum_q, bus.rx_data);
               end else begin
                  // Checksum slot: compared only, never written to the GPR.
`ifdef GPR_CTX_CSUM_EN
                  csum_err_d = (bus.rx_data != csum_q);
`else
                  csum_err_d = 1'b0;
`endif
               end
               idx_d = idx_q + CNT_W'(1);
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RESTORE;
               end
            end else begin
               state_d = ST_RESTORE;
            end
         end

         ST_DONE: begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
         end

         default: begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
         end
      endcase

      // Status outputs are registered from the next state so they align
      // with the state they describe.
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_DONE);
      rx_ready_d = (state_d == ST_RESTORE);
   end

   // State and datapath registers; reset returns every output to idle values.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         idx_q      <= {CNT_W{1'b0}};
         tx_valid_q <= 1'b0;
         tx_data_q  <= {DATA_W{1'b0}};
         we_n_q     <= 1'b1;
         wr_addr_q  <= {ADDR_W{1'b0}};
         wr_data_q  <= {DATA_W{1'b0}};
         csum_q     <= {DATA_W{1'b0}};
         csum_err_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rx_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         we_n_q     <= we_n_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         csum_q     <= csum_d;
         csum_err_q <= csum_err_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rx_ready_q <= rx_ready_d;
      end
   end

   assign busy_o          = busy_q;
   assign pipe_stall_o    = busy_q;
   assign done_o          = done_q;
   assign csum_err_o      = csum_err_q;
   assign bus.gpr_rd_addr = idx_q[ADDR_W-1:0];
   assign bus.gpr_we_     = we_n_q;
   assign bus.gpr_wr_addr = wr_addr_q;
   assign bus.gpr_wr_data = wr_data_q;
   assign bus.tx_valid    = tx_valid_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.rx_ready    = rx_ready_q;

endmodule

// File: doc/gpr_ctx_ctrl.md
# gpr_ctx_ctrl

Context save/restore engine for the general purpose register file. On a save request it reads all `REG_NUM` registers through one GPR read port and streams them out over a valid/ready interface. On a restore request it accepts a word stream and writes it back through the GPR write port. It sits beside the GPR in the CPU, is used by the exception/debug controller for context switches, and holds `pipe_stall` asserted while it owns the register file.

## Interface
- `REG_NUM`, 32: number of GPRs transferred.
- `ADDR_W`, 5: GPR address width, clog2(`REG_NUM`).
- `DATA_W`, 32: word width.

- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_save`  in  1  one-cycle request to save; sampled only in IDLE.
- `start_restore`  in  1  one-cycle request to restore; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `pipe_stall`  out  1  equals `busy`.
- `done`  out  1  one-cycle pulse at end of operation.
- `gpr_rd_addr`  out  ADDR_W  GPR read-port address.
- `gpr_rd_data`  in  DATA_W  combinational GPR read data.
- `gpr_we_`  out  1  GPR write enable, active-low.
- `gpr_wr_addr`  out  ADDR_W  GPR write address.
- `gpr_wr_data`  out  DATA_W  GPR write data.
- `tx_valid` / `tx_data`  out  1 / DATA_W  save stream (registered).
- `tx_ready`  in  1  save stream sink ready.
- `rx_valid` / `rx_data`  in  1 / DATA_W  restore stream.
- `rx_ready`  out  1  restore stream ready.
- `csum_err`  out  1  checksum mismatch flag (only with `GPR_CTX_CSUM_EN`).

## Operation
- States: IDLE, SAVE, RESTORE, DONE. Index counter `idx`, 0..`REG_NUM` (plus one extra slot with the checksum).
- IDLE:
  - `start_save` → SAVE, `idx`=0.
  - Otherwise `start_restore` → RESTORE, `idx`=0.
  - If both are high, save wins.
- Start pulses outside IDLE are ignored.
- SAVE:
  - `gpr_rd_addr`=`idx`.
  - When `!tx_valid || tx_ready` and words remain: `tx_data`<=`gpr_rd_data`, `tx_valid`<=1, `idx`++.
  - When the output is consumed and no words remain: `tx_valid`<=0.
  - Throughput is one word per cycle. `tx_data` must hold stable while `tx_valid && !tx_ready`.
- SAVE → DONE: the cycle after the handshake of the final word.
- RESTORE:
  - `rx_ready`=1.
  - On `rx_valid && rx_ready`, the next cycle presents a one-cycle registered write: `gpr_we_`=0, `gpr_wr_addr`=`idx`, `gpr_wr_data`=`rx_data`. Then `idx`++.
- RESTORE → DONE: on acceptance of the final word. The last write is presented during DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `rx_ready`=0 outside RESTORE. `gpr_we_`=1 except on the write cycles above.
- Reset values: state IDLE, `idx`=0, `busy`=0, `pipe_stall`=0, `done`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=0, `gpr_we_`=1, `gpr_wr_addr`=0, `gpr_wr_data`=0, `gpr_rd_addr`=0, `csum_err`=0.
- Reset mid-operation aborts immediately to the reset values. A partial restore is not undone.

## Timing
- Save, `tx_ready` held high:
  - `start_save` at cycle 0; SAVE at 1.
  - `tx_valid` with gpr[k] at cycle 2+k.
  - Last handshake at cycle 33; `done` at 34; IDLE at 35.
- Each `tx_ready`-low cycle adds one cycle.
- Restore, `rx_valid` held high:
  - `start_restore` at cycle 0; word k accepted at cycle 1+k.
  - Write of word k visible at cycle 2+k.
  - Final write and `done` at cycle 33.
- Each `rx_valid`-low cycle adds one cycle.
- `pipe_stall` is high from cycle 1 through the `done` cycle inclusive.

## Configuration
- `GPR_CTX_CSUM_EN` defined:
  - Save appends one extra word, the XOR of all `REG_NUM` words, as word `REG_NUM`.
  - Restore accepts `REG_NUM`+1 words. The extra word is compared with the XOR of the words received and is not written to the GPR.
  - `csum_err` is set in the DONE cycle on mismatch and holds until the next start or reset.
  - All timings lengthen by one cycle.
- Undefined: exactly `REG_NUM` words per transfer; `csum_err` tied to 0.

## Test plan
- Preload gpr[k]=k*0x01010101, pulse `start_save`, `tx_ready`=1 → 32 words in order at cycles 2..33, `done` at cycle 34, `pipe_stall` high cycles 1..34.
- Save with `tx_ready` toggling 1,0,1,0 → each word held stable while stalled, no word lost or duplicated, `done` after 64 handshake-relevant cycles.
- Restore stream 0xA0000000+k with `rx_valid`=1 → `gpr_we_`=0 cycles 2..33 with addresses 0..31, gpr[31]=0xA000001F, `done` at cycle 33.
- `start_save` and `start_restore` on the same cycle → save performed, `rx_ready` stays 0; `start_restore` during SAVE is ignored.
- Assert `reset` at cycle 10 of a restore → next cycle all outputs at reset values, gpr[0..8] retain the restored values, gpr[9..31] unchanged.
- With `GPR_CTX_CSUM_EN`: save then restore the captured 33 words → `csum_err`=0; repeat with word 5 corrupted → `csum_err`=1 in the DONE cycle.
